// File: rtl/turn_signal_seq.sv
// turn_signal_seq: left/right/hazard lamp controller, LAMPS lamps per side.
// Define TURN_SEQ_SWEEP_EN for the outward sweep; otherwise sides blink whole.
module turn_signal_seq #(
    parameter int TICK_DIV = 12500000,
    parameter int LAMPS    = 3
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             left_req,
    input  logic             right_req,
    input  logic             hazard_req,
    output logic [LAMPS-1:0] LEDL,
    output logic [LAMPS-1:0] LEDR,
    output logic [1:0]       mode,
    output logic             step_tick
);

    localparam int CW = $clog2(TICK_DIV);
`ifdef TURN_SEQ_SWEEP_EN
    localparam int PW = $clog2(LAMPS + 1);
`else
    localparam int PW = 1;
`endif

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_LEFT  = 2'd1,
        M_RIGHT = 2'd2,
        M_HAZ   = 2'd3
    } mode_t;

    mode_t            mode_q;
    mode_t            mode_n;
    mode_t            req_mode;
    logic [CW-1:0]    presc_q;
    logic [CW-1:0]    presc_n;
    logic [PW-1:0]    phase_q;
    logic [PW-1:0]    phase_n;
    logic [PW-1:0]    last_phase;
    logic             cur_tick;
    logic             tick_n;
    logic [LAMPS-1:0] side_pat;
    logic [LAMPS-1:0] ledl_n;
    logic [LAMPS-1:0] ledr_n;
    logic             req_haz;
    logic             req_left;
    logic             req_right;

    assign req_haz   = hazard_req | (left_req & right_req);
    assign req_left  = left_req & ~right_req & ~hazard_req;
    assign req_right = right_req & ~left_req & ~hazard_req;

    // Arbitrate the level requests into one requested mode.
    always_comb begin
        req_mode = M_IDLE;
        unique case (1'b1)
            req_haz:   req_mode = M_HAZ;
            req_left:  req_mode = M_LEFT;
            req_right: req_mode = M_RIGHT;
            default:   req_mode = M_IDLE;
        endcase
    end

    // Next mode, prescaler and phase; a mode change restarts the pattern.
    always_comb begin
        mode_n     = mode_q;
        presc_n    = presc_q;
        phase_n    = phase_q;
        cur_tick   = (mode_q != M_IDLE) && (presc_q == CW'(TICK_DIV - 1));
`ifdef TURN_SEQ_SWEEP_EN
        last_phase = (mode_q == M_HAZ) ? PW'(1) : PW'(LAMPS);
`else
        last_phase = PW'(1);
`endif
        if (req_mode != mode_q) begin
            mode_n  = req_mode;
            presc_n = '0;
            phase_n = '0;
        end else if (mode_q == M_IDLE) begin
            presc_n = '0;
            phase_n = '0;
        end else if (cur_tick) begin
            presc_n = '0;
            phase_n = (phase_q == last_phase) ? '0 : phase_q + PW'(1);
        end else begin
            presc_n = presc_q + CW'(1);
        end
        tick_n = (mode_n != M_IDLE) && (presc_n == CW'(TICK_DIV - 1));
    end

    // Lamp pattern for the upcoming mode/phase, so lamps track mode exactly.
    always_comb begin
        side_pat = '0;
        ledl_n   = '0;
        ledr_n   = '0;
`ifdef TURN_SEQ_SWEEP_EN
        for (int i = 0; i < LAMPS; i++) begin
            side_pat[i] = (i < int'(phase_n));
        end
`else
        side_pat = (phase_n != '0) ? '1 : '0;
`endif
        case (mode_n)
            M_LEFT:  ledl_n = side_pat;
            M_RIGHT: ledr_n = side_pat;
            M_HAZ: begin
                ledl_n = (phase_n != '0) ? '1 : '0;
                ledr_n = (phase_n != '0) ? '1 : '0;
            end
            default: begin
                ledl_n = '0;
                ledr_n = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q    <= M_IDLE;
            presc_q   <= '0;
            phase_q   <= '0;
            LEDL      <= '0;
            LEDR      <= '0;
            step_tick <= 1'b0;
        end else begin
            mode_q    <= mode_n;
            presc_q   <= presc_n;
            phase_q   <= phase_n;
            LEDL      <= ledl_n;
            LEDR      <= ledr_n;
            step_tick <= tick_n;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_turn_signal_seq.sv
// tb_turn_signal_seq: directed stimulus with a queued-expectation scoreboard.
// Runs with TICK_DIV=4, LAMPS=3; follows TURN_SEQ_SWEEP_EN like the design.
module tb_turn_signal_seq;

    typedef struct packed {
        logic [1:0] m;
        logic [2:0] l;
        logic [2:0] r;
        logic       t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       left_req;
    logic       right_req;
    logic       hazard_req;
    logic [2:0] LEDL;
    logic [2:0] LEDR;
    logic [1:0] mode;
    logic       step_tick;

    int    tests = 0;
    int    fails = 0;
    exp_t  q[$];
    string nq[$];

    turn_signal_seq #(.TICK_DIV(4), .LAMPS(3)) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .left_req  (left_req),
        .right_req (right_req),
        .hazard_req(hazard_req),
        .LEDL      (LEDL),
        .LEDR      (LEDR),
        .mode      (mode),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    // Expected outputs k cycles after entering mode m.
    function automatic exp_t ex(input int m, input int k);
        exp_t e;
        logic [2:0] tab [4];
        int nph;
        int ph;
        tab[0] = 3'b000;
        tab[1] = 3'b001;
        tab[2] = 3'b011;
        tab[3] = 3'b111;
`ifdef TURN_SEQ_SWEEP_EN
        nph = (m == 3) ? 2 : 4;
`else
        nph = 2;
`endif
        ph  = (k / 4) % nph;
        e   = '0;
        e.m = 2'(m);
        if (m != 0) e.t = ((k % 4) == 3);
        if (nph == 2) ph = ph * 3;
        case (m)
            1: e.l = tab[ph];
            2: e.r = tab[ph];
            3: begin
                e.l = tab[ph];
                e.r = tab[ph];
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc(input logic l, input logic r, input logic h,
                       input exp_t e, input string nm);
        left_req   = l;
        right_req  = r;
        hazard_req = h;
        q.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input exp_t got, input exp_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got m=%0d L=%b R=%b t=%b want m=%0d L=%b R=%b t=%b",
                     nm, got.m, got.l, got.r, got.t,
                     want.m, want.l, want.r, want.t);
        end
    endtask

    // Monitor: compare DUT outputs after each edge against queued expectations.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                chk(nm, {mode, LEDL, LEDR, step_tick}, e);
            end
        end
    end

    initial begin
        exp_t on_x;
        rst_n      = 1'b0;
        left_req   = 1'b1;
        right_req  = 1'b0;
        hazard_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, ex(0, 0), "reset");
        rst_n = 1'b1;
        for (int k = 0; k < 28; k++) cyc(1, 0, 0, ex(1, k), "left");
        for (int k = 0; k < 12; k++) cyc(0, 1, 0, ex(2, k), "right");
        for (int k = 0; k < 12; k++) cyc(1, 1, 0, ex(3, k), "haz_lr");
        for (int k = 12; k < 14; k++) cyc(0, 0, 1, ex(3, k), "haz_req");
        on_x = ex(3, 13);
        chk("haz_on", {mode, LEDL, LEDR, step_tick}, on_x);
        #2 rst_n = 1'b0;
        #1 chk("async_clr", {mode, LEDL, LEDR, step_tick}, exp_t'(0));
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) cyc(0, 0, 1, ex(3, k), "haz_restart");
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, ex(0, 0), "idle");
        for (int k = 0; k < 6; k++) cyc(1, 0, 0, ex(1, k), "left2");
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/turn_signal_seq.md
Name: turn_signal_seq

Overview:
- Parametrised turn-signal lamp controller: left, right and hazard modes driving N lamps per side, with an optional outward sequential sweep.
- Successor to the single-LED fixed-rate blinker. Adds exact-period tick generation, async reset, mode arbitration and multi-lamp patterns.
- Sits between the debounced switch/key inputs and the board LED outputs.

Parameters:
- TICK_DIV, 12500000, CLOCK_50 cycles per pattern step (0.25 s at 50 MHz); must be >= 2.
- LAMPS, 3, lamps per side; must be >= 1.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous active-low reset.
- left_req  in  1  level; left indicator requested.
- right_req  in  1  level; right indicator requested.
- hazard_req  in  1  level; hazard requested.
- LEDL  out  LAMPS  left lamps; bit 0 is innermost.
- LEDR  out  LAMPS  right lamps; bit 0 is innermost.
- mode  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
- step_tick  out  1  one-cycle pulse on each pattern step (debug/bench).

Behaviour:
- Clocking and reset:
  - Single clock: CLOCK_50.
  - RESET_N is asynchronous and active-low.
  - Reset clears prescaler, phase, mode (IDLE), LEDL, LEDR and step_tick to 0.
  - Assertion mid-pattern clears immediately. Operation resumes on the first clock edge after deassertion.
- Inputs: synchronous to CLOCK_50; synchronisation and debounce happen upstream.
- Requested mode, evaluated every cycle with this priority:
  - hazard_req = 1, or left_req = right_req = 1 -> HAZARD.
  - left_req only -> LEFT.
  - right_req only -> RIGHT.
  - none -> IDLE.
- Mode register update:
  - When the requested mode differs from the mode register, the register is loaded on the next edge.
  - On the same edge, prescaler and phase are forced to 0.
  - A mode change wins over a coincident step_tick.
- Prescaler:
  - Counts 0..TICK_DIV-1 while mode != IDLE; held at 0 in IDLE.
  - step_tick = 1 exactly when the prescaler equals TICK_DIV-1. It then wraps to 0.
  - Step period is exactly TICK_DIV cycles (no off-by-one).
  - Width is clog2(TICK_DIV).
- Phase counter:
  - Advances on step_tick.
  - LEFT/RIGHT: phases 0..LAMPS, wrapping LAMPS -> 0.
  - HAZARD: phases 0..1.
- Lamp outputs are registered from mode and phase:
  - IDLE: all lamps 0.
  - LEFT: LEDR = 0. LEDL lights bits 0..phase-1 (phase 0 = all off; phase LAMPS = all on). Full cycle = (LAMPS+1)*TICK_DIV.
  - RIGHT: mirror of LEFT, on LEDR.
  - HAZARD: phase 0 = all lamps off on both sides; phase 1 = all lamps on. Period 2*TICK_DIV.
- Mode entry:
  - Every pattern begins at phase 0 (dark), one cycle after the mode change.
  - Switching LEFT -> RIGHT clears LEDL in that same cycle.
- Output: mode mirrors the mode register.

Optional Feature:
- Macro: TURN_SEQ_SWEEP_EN.
- Defined: LEFT/RIGHT use the sequential sweep above.
- Undefined: LEFT/RIGHT blink all LAMPS of the side together, using the 2-phase pattern identical to HAZARD on one side only.
  - Phase counter is 1 bit.
  - Sweep logic is removed.
- HAZARD and IDLE behaviour is unchanged in both builds.

Test Plan:
All scenarios use TICK_DIV=4 and LAMPS=3.
1. Reset: hold RESET_N=0 for 3 cycles with left_req=1 -> LEDL=000, LEDR=000, mode=0. Release -> mode=1 one edge later.
2. LEFT sweep (sweep enabled): left_req=1 held for 20 cycles -> LEDL steps 000,001,011,111,000, each held 4 cycles; LEDR=000 throughout; step_tick every 4th cycle.
3. Hazard priority: left_req=1 and right_req=1 together -> mode=3; LEDL=LEDR=000 for 4 cycles, then 111/111 for 4 cycles, repeating.
4. Mode switch mid-pattern: LEFT at LEDL=011, then drop left_req and raise right_req -> next edge mode=2, LEDL=000, phase restarts; LEDR=001 appears 4 cycles later.
5. Async reset mid-operation: pulse RESET_N low between clock edges during HAZARD on-phase -> outputs go to 0 without waiting for a clock edge; pattern restarts from phase 0 after release.
6. Macro undefined: left_req=1 -> LEDL alternates 000 / 111 every 4 cycles; LEDR=000.
